// File: rtl/gyro_axi_pkg.sv
// Shared AXI write-side types for the memory responder and its bench.
// Response codes, burst encodings and the responder FSM state live here.
package gyro_axi_pkg;

  localparam int AXI_LEN_W   = 8;
  localparam int AXI_SIZE_W  = 3;
  localparam int AXI_BURST_W = 2;
  localparam int AXI_RESP_W  = 2;

  typedef enum logic [AXI_RESP_W-1:0] {
    OKAY   = 2'd0,
    EXOKAY = 2'd1,
    SLVERR = 2'd2,
    DECERR = 2'd3
  } resp_e;

  typedef enum logic [AXI_BURST_W-1:0] {
    FIXED = 2'd0,
    INCR  = 2'd1,
    WRAP  = 2'd2
  } burst_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    RESP = 2'd2
  } state_e;

  function automatic logic resp_is_err(input resp_e r);
    return r != OKAY;
  endfunction

endpackage

// File: rtl/axi_wo_if.sv
// Write-only AXI4 channel bundle (AW, W, B) between a DMA producer
// and a memory-side consumer.
interface axi_wo_if
  import gyro_axi_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64,
  parameter int ID_W   = 4
) ();

  logic [ID_W-1:0]        awid;
  logic [ADDR_W-1:0]      awaddr;
  logic [AXI_LEN_W-1:0]   awlen;
  logic [AXI_SIZE_W-1:0]  awsize;
  logic [AXI_BURST_W-1:0] awburst;
  logic                   awvalid;
  logic                   awready;

  logic [DATA_W-1:0]      wdata;
  logic [DATA_W/8-1:0]    wstrb;
  logic                   wlast;
  logic                   wvalid;
  logic                   wready;

  logic [ID_W-1:0]        bid;
  logic [AXI_RESP_W-1:0]  bresp;
  logic                   bvalid;
  logic                   bready;

  modport master (
    output awid, awaddr, awlen, awsize, awburst, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready
  );

  modport consumer (
    input  awid, awaddr, awlen, awsize, awburst, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready
  );

endinterface

// File: rtl/bram_bw_1r1w.sv
// Byte-write-enable simple dual-port RAM: one write port, one registered
// read port, read-first on address collision, contents never reset.
module bram_bw_1r1w #(
  parameter int DATA_W = 64,
  parameter int DEPTH  = 1024
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [DATA_W-1:0]        wdata,
  input  logic [DATA_W/8-1:0]      wstrb,
  input  logic                     re,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [DATA_W-1:0]        rdata
);

  localparam int STRB_W = DATA_W / 8;

  // One narrow array per byte lane so each lane maps onto its own write enable.
  generate
    for (genvar gi = 0; gi < STRB_W; gi++) begin : g_lane
      logic [7:0] lane_mem [DEPTH];
      logic [7:0] lane_rd_q;

      always_ff @(posedge clk) begin
        if (we && wstrb[gi]) begin
          lane_mem[waddr] <= wdata[gi*8 +: 8];
        end
        if (re) begin
          lane_rd_q <= lane_mem[raddr];
        end
      end

      assign rdata[gi*8 +: 8] = lane_rd_q;
    end
  endgenerate

endmodule

// File: rtl/axi_wo_mem_responder.sv
// AXI4 write-only responder: accepts one burst at a time into a word-addressed
// memory window, answers with OKAY/SLVERR/DECERR and offers a side read port.
module axi_wo_mem_responder
  import gyro_axi_pkg::*;
#(
  parameter int                ADDR_W    = 32,
  parameter int                DATA_W    = 64,
  parameter int                ID_W      = 4,
  parameter int                DEPTH     = 1024,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic                     clk,
  input  logic                     rstn,
  axi_wo_if.consumer               wr_axi_if,
  input  logic                     rd_en,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [DATA_W-1:0]        rd_data,
  output logic [31:0]              burst_cnt,
  output logic [31:0]              err_cnt
);

  localparam int STRB_W  = DATA_W / 8;
  localparam int BYTE_SH = $clog2(STRB_W);
  localparam int MEM_AW  = $clog2(DEPTH);
  // One spare MSB keeps an INCR burst from wrapping back into the window.
  localparam int WA_W    = ADDR_W - BYTE_SH + 1;

  localparam logic [WA_W-1:0]       BASE_WORD   = WA_W'(BASE_ADDR >> BYTE_SH);
  localparam logic [WA_W-1:0]       DEPTH_WORDS = WA_W'(DEPTH);
  localparam logic [AXI_SIZE_W-1:0] SIZE_NATIVE = AXI_SIZE_W'(BYTE_SH);

  state_e                 state_q, state_d;
  logic [ID_W-1:0]        id_q, id_d;
  logic [WA_W-1:0]        waddr_q, waddr_d;
  logic [AXI_LEN_W-1:0]   beats_q, beats_d;
  logic                   fixed_q, fixed_d;
  resp_e                  err_q, err_d;

  logic                   awready_q, awready_d;
  logic                   wready_q, wready_d;
  logic                   bvalid_q, bvalid_d;
  resp_e                  bresp_q, bresp_d;
  logic [ID_W-1:0]        bid_q, bid_d;
  logic [31:0]            burst_cnt_q, burst_cnt_d;
  logic [31:0]            err_cnt_q, err_cnt_d;
  logic                   rd_seen_q;

  logic                   aw_hs;
  logic                   w_hs;
  logic                   b_hs;
  logic [WA_W-1:0]        word_off;
  logic                   in_win;
  logic                   mem_we;
  logic [DATA_W-1:0]      mem_rdata;

  assign aw_hs = wr_axi_if.awvalid && awready_q;
  assign w_hs  = wr_axi_if.wvalid && wready_q;
  assign b_hs  = bvalid_q && wr_axi_if.bready;

  // Addresses below the base wrap to a huge offset, so one compare covers both edges.
  assign word_off = waddr_q - BASE_WORD;
  assign in_win   = word_off < DEPTH_WORDS;

  // State and burst context register
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= IDLE;
      id_q    <= '0;
      waddr_q <= '0;
      beats_q <= '0;
      fixed_q <= 1'b0;
      err_q   <= OKAY;
    end else begin
      state_q <= state_d;
      id_q    <= id_d;
      waddr_q <= waddr_d;
      beats_q <= beats_d;
      fixed_q <= fixed_d;
      err_q   <= err_d;
    end
  end

  // Next-state, address generation and burst checks
  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    waddr_d = waddr_q;
    beats_d = beats_q;
    fixed_d = fixed_q;
    err_d   = err_q;
    mem_we  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (aw_hs) begin
          id_d    = wr_axi_if.awid;
          waddr_d = WA_W'(wr_axi_if.awaddr >> BYTE_SH);
          beats_d = wr_axi_if.awlen;
          fixed_d = (wr_axi_if.awburst == FIXED);
          err_d   = ((wr_axi_if.awburst == WRAP) || (wr_axi_if.awsize != SIZE_NATIVE))
                    ? SLVERR : OKAY;
          state_d = DATA;
        end
      end

      DATA: begin
        if (w_hs) begin
          if (err_q != SLVERR) begin
            if (in_win) begin
              mem_we = 1'b1;
            end else begin
              err_d = DECERR;
            end
          end
          if (!fixed_q) begin
            waddr_d = waddr_q + 1'b1;
          end
          // Final counted beat: finish on wlast, otherwise drain until it shows up.
          if (beats_q == '0) begin
            if (wr_axi_if.wlast) begin
              state_d = RESP;
            end else begin
              err_d = SLVERR;
            end
          end else begin
            beats_d = beats_q - 1'b1;
            if (wr_axi_if.wlast) begin
              err_d   = SLVERR;
              state_d = RESP;
            end
          end
        end
      end

      RESP: begin
        if (b_hs) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // Registered channel outputs and completion counters
  always_comb begin
    awready_d   = (state_d == IDLE);
    wready_d    = (state_d == DATA);
    bvalid_d    = (state_d == RESP);
    bresp_d     = (state_d == RESP) ? err_d : OKAY;
    bid_d       = (state_d == RESP) ? id_d : '0;
    burst_cnt_d = burst_cnt_q;
    err_cnt_d   = err_cnt_q;
    if (b_hs) begin
      burst_cnt_d = burst_cnt_q + 32'd1;
      if (resp_is_err(bresp_q)) begin
        err_cnt_d = err_cnt_q + 32'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      awready_q   <= 1'b0;
      wready_q    <= 1'b0;
      bvalid_q    <= 1'b0;
      bresp_q     <= OKAY;
      bid_q       <= '0;
      burst_cnt_q <= '0;
      err_cnt_q   <= '0;
    end else begin
      awready_q   <= awready_d;
      wready_q    <= wready_d;
      bvalid_q    <= bvalid_d;
      bresp_q     <= bresp_d;
      bid_q       <= bid_d;
      burst_cnt_q <= burst_cnt_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  // The RAM read register has no reset, so rd_data reads as zero until the first read.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      rd_seen_q <= 1'b0;
    end else if (rd_en) begin
      rd_seen_q <= 1'b1;
    end
  end

  bram_bw_1r1w #(
    .DATA_W(DATA_W),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk  (clk),
    .we   (mem_we && rstn),
    .waddr(word_off[MEM_AW-1:0]),
    .wdata(wr_axi_if.wdata),
    .wstrb(wr_axi_if.wstrb),
    .re   (rd_en),
    .raddr(rd_addr),
    .rdata(mem_rdata)
  );

  assign wr_axi_if.awready = awready_q;
  assign wr_axi_if.wready  = wready_q;
  assign wr_axi_if.bvalid  = bvalid_q;
  assign wr_axi_if.bresp   = bresp_q;
  assign wr_axi_if.bid     = bid_q;

  assign rd_data   = rd_seen_q ? mem_rdata : '0;
  assign burst_cnt = burst_cnt_q;
  assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_axi_wo_mem_responder.sv
// Directed bench for axi_wo_mem_responder: bursts, strobes, window overflow,
// protocol errors, reset mid-burst and side-port read collision.
module tb_axi_wo_mem_responder;
  import gyro_axi_pkg::*;

  localparam int          DEPTH = 16;
  localparam logic [31:0] BASE  = 32'h0001_0000;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        rd_en = 1'b0;
  logic [3:0]  rd_addr = '0;
  logic [63:0] rd_data;
  logic [31:0] burst_cnt;
  logic [31:0] err_cnt;

  int checks_cnt = 0;
  int errors_cnt = 0;
  logic [63:0] exp_mem [DEPTH];
  logic [63:0] rd_val;

  axi_wo_if #(.ADDR_W(32), .DATA_W(64), .ID_W(4)) bus ();

  axi_wo_mem_responder #(
    .ADDR_W(32), .DATA_W(64), .ID_W(4), .DEPTH(DEPTH), .BASE_ADDR(BASE)
  ) dut (
    .clk      (clk),
    .rstn     (rstn),
    .wr_axi_if(bus),
    .rd_en    (rd_en),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .burst_cnt(burst_cnt),
    .err_cnt  (err_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks_cnt++;
    if (got !== exp) begin
      errors_cnt++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // All helpers start and end on a negedge.
  task automatic do_aw(input logic [31:0] addr, input logic [7:0] len,
                       input logic [1:0] burst, input logic [3:0] id);
    int n = 0;
    bus.awvalid = 1'b1; bus.awaddr = addr; bus.awlen = len;
    bus.awburst = burst; bus.awsize = 3'd3; bus.awid = id;
    while (!bus.awready && n < 40) begin @(negedge clk); n++; end
    if (!bus.awready) check_eq("aw_timeout", {63'd0, bus.awready}, 64'd1);
    @(negedge clk);
    bus.awvalid = 1'b0;
  endtask

  task automatic w_beat(input logic [63:0] data, input logic [7:0] strb,
                        input logic last, input int gap);
    int n = 0;
    repeat (gap) begin bus.wvalid = 1'b0; @(negedge clk); end
    bus.wvalid = 1'b1; bus.wdata = data; bus.wstrb = strb; bus.wlast = last;
    while (!bus.wready && n < 40) begin @(negedge clk); n++; end
    if (!bus.wready) check_eq("w_timeout", {63'd0, bus.wready}, 64'd1);
    @(negedge clk);
    bus.wvalid = 1'b0; bus.wlast = 1'b0;
  endtask

  task automatic wait_b(input resp_e resp, input logic [3:0] id, input int hold, input string tag);
    int n = 0;
    while (!bus.bvalid && n < 40) begin @(negedge clk); n++; end
    check_eq({tag, "_bvalid"}, {63'd0, bus.bvalid}, 64'd1);
    check_eq({tag, "_bresp"}, {62'd0, bus.bresp}, {62'd0, resp});
    check_eq({tag, "_bid"}, {60'd0, bus.bid}, {60'd0, id});
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check_eq($sformatf("%s_bhold%0d", tag, h), {61'd0, bus.bvalid, bus.bresp}, {61'd0, 1'b1, resp});
    end
    bus.bready = 1'b1;
    @(negedge clk);
    bus.bready = 1'b0;
    $display("burst %s id=%0d bresp=%0d burst_cnt=%0d err_cnt=%0d", tag, id, resp, burst_cnt, err_cnt);
  endtask

  task automatic check_mem(input int idx, input string tag);
    rd_en = 1'b1; rd_addr = idx[3:0];
    @(negedge clk);
    rd_en = 1'b0;
    check_eq($sformatf("%s_mem%0d", tag, idx), rd_data, exp_mem[idx]);
  endtask

  initial begin
    bus.awvalid = 1'b0; bus.awid = '0; bus.awaddr = '0; bus.awlen = '0;
    bus.awsize = 3'd3; bus.awburst = INCR;
    bus.wvalid = 1'b0; bus.wdata = '0; bus.wstrb = '0; bus.wlast = 1'b0;
    bus.bready = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    check_eq("rst_awready", {63'd0, bus.awready}, 64'd0);
    check_eq("rst_wready", {63'd0, bus.wready}, 64'd0);
    check_eq("rst_bvalid", {63'd0, bus.bvalid}, 64'd0);
    check_eq("rst_bresp", {62'd0, bus.bresp}, 64'd0);
    check_eq("rst_bid", {60'd0, bus.bid}, 64'd0);
    check_eq("rst_rd_data", rd_data, 64'd0);
    check_eq("rst_burst_cnt", {32'd0, burst_cnt}, 64'd0);
    check_eq("rst_err_cnt", {32'd0, err_cnt}, 64'd0);
    rstn = 1'b1;
    @(negedge clk);
    check_eq("rst_awready_rise", {63'd0, bus.awready}, 64'd1);

    // Single beat
    do_aw(BASE + 32'h10, 8'd0, INCR, 4'd3);
    check_eq("single_wready", {63'd0, bus.wready}, 64'd1);
    check_eq("single_no_aw", {63'd0, bus.awready}, 64'd0);
    w_beat(64'h1122_3344_5566_7788, 8'hFF, 1'b1, 0);
    check_eq("single_b_latency", {63'd0, bus.bvalid}, 64'd1);
    wait_b(OKAY, 4'd3, 0, "single");
    check_eq("single_burst_cnt", {32'd0, burst_cnt}, 64'd1);
    exp_mem[2] = 64'h1122_3344_5566_7788;
    check_mem(2, "single");

    // Known contents for words 0..7
    do_aw(BASE, 8'd7, INCR, 4'd1);
    for (int i = 0; i < 8; i++) begin
      w_beat('1, 8'hFF, (i == 7), 0);
      exp_mem[i] = '1;
    end
    wait_b(OKAY, 4'd1, 0, "prefill");

    // INCR len=7 with alternating strobes, W gaps and 3 cycles of B backpressure
    do_aw(BASE, 8'd7, INCR, 4'd5);
    for (int i = 0; i < 8; i++) begin
      w_beat({32'hC000_0000 + i, 32'hD000_0000 + i}, (i % 2) ? 8'hF0 : 8'h0F, (i == 7), i % 2);
      exp_mem[i] = (i % 2) ? {32'hC000_0000 + i, 32'hFFFF_FFFF} : {32'hFFFF_FFFF, 32'hD000_0000 + i};
    end
    wait_b(OKAY, 4'd5, 3, "strobe");
    for (int i = 0; i < 8; i++) check_mem(i, "strobe");

    // Window overflow: last two words written, no wrap to words 0/1
    do_aw(BASE + (DEPTH - 2) * 8, 8'd3, INCR, 4'd6);
    for (int i = 0; i < 4; i++) w_beat(64'h5500_0000_0000_0000 + i, 8'hFF, (i == 3), 0);
    exp_mem[14] = 64'h5500_0000_0000_0000;
    exp_mem[15] = 64'h5500_0000_0000_0001;
    wait_b(DECERR, 4'd6, 0, "overflow");
    check_eq("overflow_err_cnt", {32'd0, err_cnt}, 64'd1);
    check_mem(14, "overflow"); check_mem(15, "overflow");
    check_mem(0, "overflow");  check_mem(1, "overflow");

    // WRAP burst drained without writes
    do_aw(BASE, 8'd3, WRAP, 4'd7);
    for (int i = 0; i < 4; i++) w_beat(64'hDEAD_0000_0000_0000 + i, 8'hFF, (i == 3), 0);
    wait_b(SLVERR, 4'd7, 0, "wrap");
    for (int i = 0; i < 4; i++) check_mem(i, "wrap");
    check_eq("wrap_burst_cnt", {32'd0, burst_cnt}, 64'd5);
    check_eq("wrap_err_cnt", {32'd0, err_cnt}, 64'd2);

    // Early wlast on beat 1 of a len=3 burst
    do_aw(BASE + 32'h20, 8'd3, INCR, 4'd8);
    for (int i = 0; i < 2; i++) w_beat(64'h7700_0000_0000_0000 + i, 8'hFF, (i == 1), 0);
    exp_mem[4] = 64'h7700_0000_0000_0000;
    exp_mem[5] = 64'h7700_0000_0000_0001;
    wait_b(SLVERR, 4'd8, 0, "early");
    check_mem(4, "early"); check_mem(5, "early"); check_mem(6, "early");
    check_eq("early_err_cnt", {32'd0, err_cnt}, 64'd3);

    // Missing wlast on final counted beat: extra beat drained unwritten
    do_aw(BASE, 8'd1, INCR, 4'd9);
    for (int i = 0; i < 3; i++) w_beat(64'h6600_0000_0000_0000 + i, 8'hFF, (i == 2), 0);
    exp_mem[0] = 64'h6600_0000_0000_0000;
    exp_mem[1] = 64'h6600_0000_0000_0001;
    wait_b(SLVERR, 4'd9, 0, "overrun");
    check_mem(0, "overrun"); check_mem(1, "overrun"); check_mem(2, "overrun");
    check_eq("overrun_burst_cnt", {32'd0, burst_cnt}, 64'd7);
    check_eq("overrun_err_cnt", {32'd0, err_cnt}, 64'd4);

    // Reset after beat 2 of a len=7 burst
    do_aw(BASE + 32'h40, 8'd7, INCR, 4'd10);
    for (int i = 0; i < 3; i++) begin
      w_beat(64'h8800_0000_0000_0000 + i, 8'hFF, 1'b0, 0);
      exp_mem[8 + i] = 64'h8800_0000_0000_0000 + i;
    end
    rstn = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("midrst_bvalid", {63'd0, bus.bvalid}, 64'd0);
    check_eq("midrst_awready", {63'd0, bus.awready}, 64'd0);
    check_eq("midrst_wready", {63'd0, bus.wready}, 64'd0);
    check_eq("midrst_burst_cnt", {32'd0, burst_cnt}, 64'd0);
    check_eq("midrst_err_cnt", {32'd0, err_cnt}, 64'd0);
    check_eq("midrst_rd_data", rd_data, 64'd0);
    rstn = 1'b1;
    @(negedge clk);
    check_eq("midrst_awready_rise", {63'd0, bus.awready}, 64'd1);
    check_mem(8, "midrst");
    do_aw(BASE + 32'h18, 8'd0, INCR, 4'd11);
    w_beat(64'h9900_0000_0000_0003, 8'hFF, 1'b1, 0);
    exp_mem[3] = 64'h9900_0000_0000_0003;
    wait_b(OKAY, 4'd11, 0, "postrst");
    check_eq("postrst_burst_cnt", {32'd0, burst_cnt}, 64'd1);
    check_eq("postrst_err_cnt", {32'd0, err_cnt}, 64'd0);
    check_mem(3, "postrst");

    // Side read colliding with a write to the same word
    do_aw(BASE + 32'h28, 8'd0, INCR, 4'd12);
    check_eq("coll_wready", {63'd0, bus.wready}, 64'd1);
    bus.wvalid = 1'b1; bus.wdata = 64'hAAAA_AAAA_AAAA_AAAA; bus.wstrb = 8'hFF; bus.wlast = 1'b1;
    rd_en = 1'b1; rd_addr = 4'd5;
    @(negedge clk);
    bus.wvalid = 1'b0; bus.wlast = 1'b0; rd_en = 1'b0;
    check_eq("coll_old_data", rd_data, exp_mem[5]);
    exp_mem[5] = 64'hAAAA_AAAA_AAAA_AAAA;
    wait_b(OKAY, 4'd12, 0, "collision");
    check_mem(5, "coll_new");

    $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
    $finish;
  end

endmodule
